rgb2ycbcr_block_stream: RTL and testbench

Encoder-side colour converter and blockizer: accepts a raster-within-block stream of RGB pixels, one per cycle, converts each to JFIF YCbCr through a 3-stage fixed-point pipeline, and assembles complete 8x8 Y/Cb/Cr blocks in a ping-pong buffer. It sits at the encoder input, ahead of the forward DCT, and is the mirror of the decode-side YCbCr→RGB block converter.

---
 rtl/rgb2ycbcr_block_stream_pkg.sv | 44 ++++
 rtl/rgb2ycbcr_block_stream_if.sv | 27 ++
 rtl/rgb2ycbcr_block_stream_rgb2ycbcr.sv | 77 +++++++
 rtl/rgb2ycbcr_block_stream.sv | 88 ++++++++
 tb/tb_rgb2ycbcr_block_stream.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/rgb2ycbcr_block_stream_pkg.sv
// Shared constants and types for the RGB->YCbCr converter and 8x8 blockizer.
// Q8 coefficients are JFIF full-range; chroma is offset by 128 before clamping.
package jpeg_color_pkg;

  localparam int BLK_PIXELS = 64;
  localparam logic signed [17:0] ROUND_Q8   = 18'sd128;
  localparam logic signed [17:0] CHROMA_OFS = 18'sd128;

  // Rows: Y, Cb, Cr; columns: R, G, B.
  localparam logic signed [17:0] COEF [3][3] = '{
    '{ 18'sd77,   18'sd150,  18'sd29 },
    '{ -18'sd43,  -18'sd85,  18'sd128 },
    '{ 18'sd128,  -18'sd107, -18'sd21 }
  };

  typedef enum logic [1:0] {
    FREE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } bank_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  typedef struct packed {
    logic       bank;
    logic [5:0] idx;
  } px_tag_t;

  typedef logic [7:0][7:0][7:0] blk_t;

  function automatic logic [7:0] clamp8(input logic signed [17:0] v);
    if (v < 18'sd0)
      return 8'd0;
    else if (v > 18'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/rgb2ycbcr_block_stream_if.sv
// Pixel-in / block-out handshake bundle; slave is the converter, master the
// producer/consumer side.
interface rgb2ycbcr_block_stream_if;
  import jpeg_color_pkg::*;

  logic       px_valid;
  logic       px_ready;
  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;
  logic       blk_valid;
  logic       blk_ready;
  blk_t       y;
  blk_t       cb;
  blk_t       cr;

  modport master (
    output px_valid, r_in, g_in, b_in, blk_ready,
    input  px_ready, blk_valid, y, cb, cr
  );

  modport slave (
    input  px_valid, r_in, g_in, b_in, blk_ready,
    output px_ready, blk_valid, y, cb, cr
  );

endinterface

// File: rtl/rgb2ycbcr_block_stream_rgb2ycbcr.sv
// Single-pixel RGB->YCbCr pipeline: products, sums, shift/clamp; 3 cycles, no stall.
// RGB2YCBCR_LEVEL_SHIFT_EN makes outputs two's complement (MSB inverted).
module rgb2ycbcr
  import jpeg_color_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vld,
  input  pix_t       in_pix,
  input  px_tag_t    in_tag,
  output logic       out_vld,
  output px_tag_t    out_tag,
  output logic [7:0] out_y,
  output logic [7:0] out_cb,
  output logic [7:0] out_cr
);

  logic [7:0]         comp [3];
  logic               s1_vld, s2_vld, s3_vld;
  px_tag_t            s1_tag, s2_tag, s3_tag;
  logic signed [17:0] prod [3][3];
  logic signed [17:0] sum  [3];
  logic [7:0]         res  [3];

  function automatic logic [7:0] finish_px(input logic signed [17:0] s, input logic chroma);
    logic signed [17:0] v;
    logic [7:0]         c;
    v = s >>> 8;
    if (chroma)
      v = v + CHROMA_OFS;
    c = clamp8(v);
`ifdef RGB2YCBCR_LEVEL_SHIFT_EN
    c = c ^ 8'h80;
`endif
    return c;
  endfunction

  always_comb begin
    comp[0] = in_pix.r;
    comp[1] = in_pix.g;
    comp[2] = in_pix.b;
  end

  // Only the valid bits are reset; in-flight data is dropped with them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else begin
      s1_vld <= in_vld;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
    end
  end

  always_ff @(posedge clk) begin
    s1_tag <= in_tag;
    s2_tag <= s1_tag;
    s3_tag <= s2_tag;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++)
        prod[i][j] <= $signed({10'd0, comp[j]}) * COEF[i][j];
      sum[i] <= prod[i][0] + prod[i][1] + prod[i][2] + ROUND_Q8;
    end
    res[0] <= finish_px(sum[0], 1'b0);
    res[1] <= finish_px(sum[1], 1'b1);
    res[2] <= finish_px(sum[2], 1'b1);
  end

  assign out_vld = s3_vld;
  assign out_tag = s3_tag;
  assign out_y   = res[0];
  assign out_cb  = res[1];
  assign out_cr  = res[2];

endmodule

// File: rtl/rgb2ycbcr_block_stream.sv
// Converts a raster-in-block RGB stream into 8x8 Y/Cb/Cr blocks; block valid 3 cycles after pixel 63.
// Ping-pong banks: px_ready drops when both banks hold unread blocks; optional RGB2YCBCR_LEVEL_SHIFT_EN.
module rgb2ycbcr_block_stream
  import jpeg_color_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  rgb2ycbcr_block_stream_if.slave bus
);

  bank_state_t bank_st [2];
  logic        acc_bank;
  logic        rd_bank;
  logic [5:0]  acc_cnt;
  blk_t        ybuf [2];
  blk_t        cbbuf [2];
  blk_t        crbuf [2];

  logic        acc, rel;
  pix_t        px;
  px_tag_t     acc_tag;
  logic        wr_vld;
  px_tag_t     wr_tag;
  logic [7:0]  wr_y, wr_cb, wr_cr;

  assign px            = {bus.r_in, bus.g_in, bus.b_in};
  assign acc_tag       = {acc_bank, acc_cnt};
  assign bus.px_ready  = (bank_st[acc_bank] != FULL);
  assign bus.blk_valid = (bank_st[rd_bank] == FULL);
  assign acc           = bus.px_valid & bus.px_ready;
  assign rel           = bus.blk_valid & bus.blk_ready;
  assign bus.y         = ybuf[rd_bank];
  assign bus.cb        = cbbuf[rd_bank];
  assign bus.cr        = crbuf[rd_bank];

  rgb2ycbcr u_cvt (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (acc),
    .in_pix  (px),
    .in_tag  (acc_tag),
    .out_vld (wr_vld),
    .out_tag (wr_tag),
    .out_y   (wr_y),
    .out_cb  (wr_cb),
    .out_cr  (wr_cr)
  );

  // A FULL transition and a release always target different banks, so both may land together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_st[0] <= FREE;
      bank_st[1] <= FREE;
      acc_bank   <= 1'b0;
      rd_bank    <= 1'b0;
      acc_cnt    <= 6'd0;
    end else begin
      if (acc) begin
        if (bank_st[acc_bank] == FREE)
          bank_st[acc_bank] <= FILL;
        acc_cnt <= acc_cnt + 6'd1;
        if (acc_cnt == 6'(BLK_PIXELS - 1))
          acc_bank <= ~acc_bank;
      end
      if (wr_vld && wr_tag.idx == 6'(BLK_PIXELS - 1))
        bank_st[wr_tag.bank] <= FULL;
      if (rel) begin
        bank_st[rd_bank] <= FREE;
        rd_bank          <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        ybuf[b]  <= '0;
        cbbuf[b] <= '0;
        crbuf[b] <= '0;
      end
    end else if (wr_vld) begin
      ybuf[wr_tag.bank][wr_tag.idx[5:3]][wr_tag.idx[2:0]]  <= wr_y;
      cbbuf[wr_tag.bank][wr_tag.idx[5:3]][wr_tag.idx[2:0]] <= wr_cb;
      crbuf[wr_tag.bank][wr_tag.idx[5:3]][wr_tag.idx[2:0]] <= wr_cr;
    end
  end

endmodule

// File: tb/tb_rgb2ycbcr_block_stream.sv
// Directed bench for rgb2ycbcr_block_stream: expected blocks are queued at
// issue time and checked by a monitor on every block handshake.
module tb_rgb2ycbcr_block_stream;
  import jpeg_color_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rgb2ycbcr_block_stream_if bus();

  rgb2ycbcr_block_stream dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    blk_t y;
    blk_t cb;
    blk_t cr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic blk_t fill(input logic [7:0] v);
    blk_t b;
    for (int k = 0; k < 64; k++) b[k/8][k%8] = v;
    return b;
  endfunction

  function automatic blk_t ramp(input int mul, input int ofs);
    blk_t b;
    for (int k = 0; k < 64; k++) b[k/8][k%8] = 8'(mul * k + ofs);
    return b;
  endfunction

  function automatic blk_t ls(input blk_t b);
`ifdef RGB2YCBCR_LEVEL_SHIFT_EN
    return b ^ {64{8'h80}};
`else
    return b;
`endif
  endfunction

  task automatic push(input blk_t y, input blk_t cb, input blk_t cr);
    exp_t e;
    e.y  = ls(y);
    e.cb = ls(cb);
    e.cr = ls(cr);
    exp_q.push_back(e);
  endtask

  // Inputs change at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int t = 0;
    bus.px_valid = 1'b1;
    bus.r_in = r;
    bus.g_in = g;
    bus.b_in = b;
    while (!bus.px_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.px_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL px_accept_timeout: got px_ready=0 required 1 within 300 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic send_uni(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    for (int k = 0; k < 64; k++) send_px(r, g, b);
    bus.px_valid = 1'b0;
  endtask

  task automatic send_ramp(input int mul, input int ofs);
    for (int k = 0; k < 64; k++) send_px(8'(mul * k + ofs), 8'(mul * k + ofs), 8'(mul * k + ofs));
    bus.px_valid = 1'b0;
  endtask

  task automatic take_all();
    int t = 0;
    bus.blk_ready = 1'b1;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_queue", 32'(exp_q.size()), 0);
    bus.blk_ready = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && bus.blk_valid && bus.blk_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_block: got blk_valid=1 required no block pending");
      end else begin
        e = exp_q.pop_front();
        chk("blk_y",  bus.y,  e.y);
        chk("blk_cb", bus.cb, e.cb);
        chk("blk_cr", bus.cr, e.cr);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish required finish by 200000");
    $fatal(1);
  end

  initial begin
    bus.px_valid  = 1'b0;
    bus.blk_ready = 1'b0;
    bus.r_in = 8'd0;
    bus.g_in = 8'd0;
    bus.b_in = 8'd0;
    rst = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(1);

    // Reset state
    chk("reset_px_ready",  bus.px_ready, 1);
    chk("reset_blk_valid", bus.blk_valid, 0);
    chk("reset_y",  bus.y,  0);
    chk("reset_cb", bus.cb, 0);
    chk("reset_cr", bus.cr, 0);

    // Gray 100 and its block latency
    push(fill(8'd100), fill(8'd128), fill(8'd128));
    send_uni(8'd100, 8'd100, 8'd100);
    cycles(2);
    chk("latency_e2_blk_valid", bus.blk_valid, 0);
    cycles(1);
    chk("latency_e3_blk_valid", bus.blk_valid, 1);
    take_all();

    // Pure blue: Cb clamps at 255, Cr floors to 107
    push(fill(8'd29), fill(8'd255), fill(8'd107));
    send_uni(8'd0, 8'd0, 8'd255);
    take_all();

    // Per-pixel ramp checks row/col placement
    push(ramp(3, 0), fill(8'd128), fill(8'd128));
    send_ramp(3, 0);
    take_all();

    // Backpressure: two blocks fill both banks, third waits for a release
    push(fill(8'd50), fill(8'd128), fill(8'd128));
    push(fill(8'd77), fill(8'd85), fill(8'd255));
    push(fill(8'd149), fill(8'd43), fill(8'd21));
    send_uni(8'd50, 8'd50, 8'd50);
    send_uni(8'd255, 8'd0, 8'd0);
    chk("bp_px_ready_after_128", bus.px_ready, 0);
    cycles(10);
    chk("bp_px_ready_held", bus.px_ready, 0);
    chk("bp_blk_valid_held", bus.blk_valid, 1);
    chk("bp_y_stable", bus.y, ls(fill(8'd50)));
    bus.blk_ready = 1'b1;
    chk("bp_px_ready_before_release", bus.px_ready, 0);
    cycles(1);
    chk("bp_px_ready_after_release", bus.px_ready, 1);
    send_uni(8'd0, 8'd255, 8'd0);
    take_all();

    // Reset mid-block discards partial data
    for (int k = 0; k < 30; k++) send_px(8'd255, 8'd255, 8'd255);
    rst = 1'b0;
    bus.px_valid = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(10);
    chk("midreset_blk_valid", bus.blk_valid, 0);
    chk("midreset_px_ready", bus.px_ready, 1);
    chk("midreset_y_cleared", bus.y, 0);
    push(ramp(4, 1), fill(8'd128), fill(8'd128));
    send_ramp(4, 1);
    cycles(3);
    chk("midreset_block_valid", bus.blk_valid, 1);
    take_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
